// File: rtl/alarm_clock_ctrl.sv
// Alarm clock mode/adjust controller: run/adjust sequencing, time step
// strobes, BCD alarm registers and alarm ringing FSM.
// Optional feature macro: ALARM_TIMEOUT_EN (ring auto-stops after RING_SECS).
// Ports: clk, rst (sync, active-low), tick_1hz, btn_c/l/r/u/d pulses,
//   alarm_sw, time digits H1 H2 M1 M2 S1 S2 -> run_en, tm_h_step,
//   tm_m_step, up_down, alarm digits AH1 AH2 AM1 AM2, disp_alarm,
//   field_led, blink, buzzer, alarm_led.
module alarm_clock_ctrl #(
  parameter int RING_SECS = 60,
  parameter int BLINK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_c,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       alarm_sw,
  input  logic [1:0] H1,
  input  logic [3:0] H2,
  input  logic [2:0] M1,
  input  logic [3:0] M2,
  input  logic [2:0] S1,
  input  logic [3:0] S2,
  output logic       run_en,
  output logic       tm_h_step,
  output logic       tm_m_step,
  output logic       up_down,
  output logic [1:0] AH1,
  output logic [3:0] AH2,
  output logic [2:0] AM1,
  output logic [3:0] AM2,
  output logic       disp_alarm,
  output logic [3:0] field_led,
  output logic       blink,
  output logic       buzzer,
  output logic       alarm_led
);

  typedef enum logic [2:0] {
    CLOCK, ADJ_TH, ADJ_TM, ADJ_AH, ADJ_AM, RINGING
  } state_t;

  localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);

  state_t state, nxt;
  logic [DW-1:0] div;
  logic raw, raw_q, trig;
  logic pc, pl, pr, pu, pd, any_btn;
  logic adj, nxt_adj, div_wrap, ring_done;

  // Priority-resolved button pulses: at most one is set.
  assign pc = btn_c;
  assign pl = btn_l & ~btn_c;
  assign pr = btn_r & ~btn_c & ~btn_l;
  assign pu = btn_u & ~(btn_c | btn_l | btn_r);
  assign pd = btn_d & ~(btn_c | btn_l | btn_r | btn_u);
  assign any_btn = btn_c | btn_l | btn_r | btn_u | btn_d;

  // Edge of the raw compare, so a persisting match (or one that was
  // already present while adjusting) never retriggers.
  assign raw = ({H1, H2, M1, M2} == {AH1, AH2, AM1, AM2})
             && (S1 == 3'd0) && (S2 == 4'd0) && alarm_sw;
  assign trig = raw & ~raw_q & (state == CLOCK);

  assign adj = (state == ADJ_TH) || (state == ADJ_TM)
            || (state == ADJ_AH) || (state == ADJ_AM);
  assign nxt_adj = (nxt == ADJ_TH) || (nxt == ADJ_TM)
                || (nxt == ADJ_AH) || (nxt == ADJ_AM);
  assign div_wrap = tick_1hz & (div == DIV_LAST);

`ifdef ALARM_TIMEOUT_EN
  localparam int RW = $clog2(RING_SECS + 1);
  logic [RW-1:0] ring_cnt;
  assign ring_done = tick_1hz
                   && (ring_cnt == RW'(RING_SECS - 1));
`else
  assign ring_done = 1'b0;
`endif

  function automatic logic [5:0] hr_step(
    input logic [1:0] t, input logic [3:0] u, input logic dn);
    logic [5:0] r;
    if (!dn) begin
      if (t == 2'd2 && u == 4'd3) r = 6'h00;
      else if (u == 4'd9)         r = {t + 2'd1, 4'd0};
      else                        r = {t, u + 4'd1};
    end else begin
      if (t == 2'd0 && u == 4'd0) r = {2'd2, 4'd3};
      else if (u == 4'd0)         r = {t - 2'd1, 4'd9};
      else                        r = {t, u - 4'd1};
    end
    return r;
  endfunction

  function automatic logic [6:0] mn_step(
    input logic [2:0] t, input logic [3:0] u, input logic dn);
    logic [6:0] r;
    if (!dn) begin
      if (t == 3'd5 && u == 4'd9) r = 7'h00;
      else if (u == 4'd9)         r = {t + 3'd1, 4'd0};
      else                        r = {t, u + 4'd1};
    end else begin
      if (t == 3'd0 && u == 4'd0) r = {3'd5, 4'd9};
      else if (u == 4'd0)         r = {t - 3'd1, 4'd9};
      else                        r = {t, u - 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    nxt = state;
    unique case (state)
      CLOCK: begin
        if (pc)        nxt = ADJ_TH;
        else if (trig) nxt = RINGING;
      end
      ADJ_TH: begin
        if (pc)      nxt = CLOCK;
        else if (pr) nxt = ADJ_TM;
        else if (pl) nxt = ADJ_AM;
      end
      ADJ_TM: begin
        if (pc)      nxt = CLOCK;
        else if (pr) nxt = ADJ_AH;
        else if (pl) nxt = ADJ_TH;
      end
      ADJ_AH: begin
        if (pc)      nxt = CLOCK;
        else if (pr) nxt = ADJ_AM;
        else if (pl) nxt = ADJ_TM;
      end
      ADJ_AM: begin
        if (pc)      nxt = CLOCK;
        else if (pr) nxt = ADJ_TH;
        else if (pl) nxt = ADJ_AH;
      end
      RINGING: begin
        if (any_btn || !alarm_sw || ring_done) nxt = CLOCK;
      end
      default: nxt = CLOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= CLOCK;
      raw_q      <= 1'b0;
      div        <= '0;
      run_en     <= 1'b1;
      tm_h_step  <= 1'b0;
      tm_m_step  <= 1'b0;
      up_down    <= 1'b0;
      AH1        <= '0;
      AH2        <= '0;
      AM1        <= '0;
      AM2        <= '0;
      disp_alarm <= 1'b0;
      field_led  <= '0;
      blink      <= 1'b0;
      buzzer     <= 1'b0;
      alarm_led  <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
      ring_cnt   <= '0;
`endif
    end else begin
      state <= nxt;
      raw_q <= raw;
      if (tick_1hz) div <= (div == DIV_LAST) ? '0 : div + 1'b1;

      tm_h_step <= (state == ADJ_TH) & (pu | pd);
      tm_m_step <= (state == ADJ_TM) & (pu | pd);
      if (adj && (pu || pd)) up_down <= pd;

      if (state == ADJ_AH && (pu || pd))
        {AH1, AH2} <= hr_step(AH1, AH2, pd);
      if (state == ADJ_AM && (pu || pd))
        {AM1, AM2} <= mn_step(AM1, AM2, pd);

      run_en     <= ~nxt_adj;
      disp_alarm <= (nxt == ADJ_AH) || (nxt == ADJ_AM);
      field_led  <= {nxt == ADJ_AM, nxt == ADJ_AH,
                     nxt == ADJ_TM, nxt == ADJ_TH};
      alarm_led  <= (nxt == RINGING);

      // Blink phase carries across field changes, restarts at 0 on entry.
      if (nxt_adj && adj) begin
        if (div_wrap) blink <= ~blink;
      end else begin
        blink <= 1'b0;
      end

      if (nxt == RINGING) begin
        if (state != RINGING) buzzer <= 1'b1;
        else if (div_wrap)    buzzer <= ~buzzer;
      end else begin
        buzzer <= 1'b0;
      end

`ifdef ALARM_TIMEOUT_EN
      if (state != RINGING) ring_cnt <= '0;
      else if (tick_1hz)    ring_cnt <= ring_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed self-checking bench for alarm_clock_ctrl.
// Runs with RING_SECS=3, BLINK_DIV=1.
module tb_alarm_clock_ctrl;

  logic clk = 1'b0;
  logic rst, tick_1hz;
  logic btn_c, btn_l, btn_r, btn_u, btn_d, alarm_sw;
  logic [1:0] H1;
  logic [3:0] H2;
  logic [2:0] M1;
  logic [3:0] M2;
  logic [2:0] S1;
  logic [3:0] S2;
  logic run_en, tm_h_step, tm_m_step, up_down;
  logic [1:0] AH1;
  logic [3:0] AH2;
  logic [2:0] AM1;
  logic [3:0] AM2;
  logic disp_alarm, blink, buzzer, alarm_led;
  logic [3:0] field_led;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alarm_clock_ctrl #(.RING_SECS(3), .BLINK_DIV(1)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r),
    .btn_u(btn_u), .btn_d(btn_d), .alarm_sw(alarm_sw),
    .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2),
    .run_en(run_en), .tm_h_step(tm_h_step), .tm_m_step(tm_m_step),
    .up_down(up_down), .AH1(AH1), .AH2(AH2), .AM1(AM1), .AM2(AM2),
    .disp_alarm(disp_alarm), .field_led(field_led), .blink(blink),
    .buzzer(buzzer), .alarm_led(alarm_led)
  );

  wire [15:0] alm = {2'b00, AH1, AH2, 1'b0, AM1, AM2};

  task automatic chk(input string tag,
                     input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // mask bits: {c,l,r,u,d}
  task automatic press(input logic [4:0] m);
    {btn_c, btn_l, btn_r, btn_u, btn_d} = m;
    cyc();
    {btn_c, btn_l, btn_r, btn_u, btn_d} = 5'b0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic settime(input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s);
    H1 = h[5:4]; H2 = h[3:0];
    M1 = m[6:4]; M2 = m[3:0];
    S1 = s[6:4]; S2 = s[3:0];
  endtask

  localparam logic [4:0] C = 5'b10000;
  localparam logic [4:0] L = 5'b01000;
  localparam logic [4:0] R = 5'b00100;
  localparam logic [4:0] U = 5'b00010;
  localparam logic [4:0] D = 5'b00001;

  initial begin
    rst = 1'b0; tick_1hz = 1'b0; alarm_sw = 1'b0;
    {btn_c, btn_l, btn_r, btn_u, btn_d} = 5'b0;
    settime(8'h12, 8'h34, 8'h56);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc();
    chk("rst_run_en", 16'(run_en), 16'd1);
    chk("rst_field", 16'(field_led), 16'h0);
    chk("rst_alarm", alm, 16'h0000);
    chk("rst_buzzer", 16'(buzzer), 16'd0);
    chk("rst_led", 16'(alarm_led), 16'd0);
    chk("rst_steps", 16'({tm_h_step, tm_m_step, up_down}), 16'd0);

    press(C);
    chk("th_field", 16'(field_led), 16'h1);
    chk("th_run_en", 16'(run_en), 16'd0);
    press(U);
    chk("th_u_step", 16'({tm_h_step, tm_m_step, up_down}), 16'b100);
    cyc();
    chk("th_step_1cyc", 16'(tm_h_step), 16'd0);
    press(D);
    chk("th_d_step", 16'({tm_h_step, tm_m_step, up_down}), 16'b101);
    tick();
    chk("th_blink1", 16'(blink), 16'd1);
    tick();
    chk("th_blink0", 16'(blink), 16'd0);

    press(R);
    chk("tm_field", 16'(field_led), 16'h2);
    press(U);
    chk("tm_u_step", 16'({tm_h_step, tm_m_step, up_down}), 16'b010);
    press(R | U);
    chk("prio_field", 16'(field_led), 16'h4);
    chk("prio_nostep", 16'(tm_m_step), 16'd0);
    chk("ah_disp", 16'(disp_alarm), 16'd1);

    press(D);
    chk("ah_00_dn", alm, 16'h2300);
    press(U);
    chk("ah_23_up", alm, 16'h0000);
    repeat (10) press(U);
    chk("ah_09_up", alm, 16'h1000);
    press(D);
    chk("ah_10_dn", alm, 16'h0900);
    repeat (2) press(D);
    chk("ah_07", alm, 16'h0700);
    press(U | U);
    chk("ah_no_steps", 16'({tm_h_step, tm_m_step}), 16'd0);
    press(D);

    press(R);
    chk("am_field", 16'(field_led), 16'h8);
    press(D);
    chk("am_00_dn", alm, 16'h0759);
    press(U);
    chk("am_59_up", alm, 16'h0700);
    repeat (30) press(U);
    chk("am_30", alm, 16'h0730);

    press(R);
    chk("wrap_r", 16'(field_led), 16'h1);
    press(L);
    chk("wrap_l", 16'(field_led), 16'h8);
    press(L);
    chk("l_ah", 16'(field_led), 16'h4);
    press(C);
    chk("clk_field", 16'({field_led, run_en, disp_alarm, blink}),
        16'b0000_1_0_0);

    settime(8'h07, 8'h30, 8'h00);
    cyc(); cyc();
    chk("sw0_noring", 16'({alarm_led, buzzer}), 16'd0);
    settime(8'h07, 8'h29, 8'h59);
    alarm_sw = 1'b1;
    cyc();
    settime(8'h07, 8'h30, 8'h00);
    cyc();
    chk("ring_led", 16'({alarm_led, buzzer, run_en}), 16'b111);
    tick();
    chk("ring_buz0", 16'(buzzer), 16'd0);
    tick();
    chk("ring_buz1", 16'(buzzer), 16'd1);
    press(D);
    chk("dismiss", 16'({alarm_led, buzzer}), 16'd0);
    chk("dismiss_field", 16'(field_led), 16'h0);
    chk("dismiss_alarm", alm, 16'h0730);
    cyc(); cyc();
    chk("no_retrig", 16'(alarm_led), 16'd0);

    settime(8'h07, 8'h29, 8'h59);
    press(C);
    press(R);
    settime(8'h07, 8'h30, 8'h00);
    cyc(); cyc();
    chk("adj_noring", 16'({alarm_led, buzzer, field_led}), 16'h002);
    press(C);
    cyc();
    chk("adj_exit_noring", 16'(alarm_led), 16'd0);

    settime(8'h07, 8'h29, 8'h59);
    cyc();
    settime(8'h07, 8'h30, 8'h00);
    cyc();
    chk("ring2", 16'(alarm_led), 16'd1);
    alarm_sw = 1'b0;
    cyc();
    chk("sw_off", 16'({alarm_led, buzzer}), 16'd0);

    alarm_sw = 1'b1;
    settime(8'h07, 8'h29, 8'h59);
    cyc();
    settime(8'h07, 8'h30, 8'h00);
    cyc();
    chk("ring3", 16'(alarm_led), 16'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("rst_ring", 16'({alarm_led, buzzer, run_en}), 16'b001);
    chk("rst_alarm_clr", alm, 16'h0000);

    settime(8'h00, 8'h00, 8'h01);
    cyc();
    settime(8'h00, 8'h00, 8'h00);
    cyc();
    chk("ring4", 16'({alarm_led, buzzer}), 16'b11);
`ifdef ALARM_TIMEOUT_EN
    tick(); tick();
    chk("to_still", 16'(alarm_led), 16'd1);
    tick();
    chk("to_done", 16'({alarm_led, buzzer}), 16'd0);
`else
    repeat (100) tick();
    chk("no_timeout", 16'({alarm_led, buzzer}), 16'b11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
